// File: rtl/accum_pkg.sv
// accum_pkg: shared state encoding and default widths for the accumulator frame sequencer.
// Rev 1.0
`default_nettype none

package accum_pkg;

  localparam int ACC_DIN_WIDTH     = 32;
  localparam int ACC_DOUT_WIDTH    = 32;
  localparam int ACC_MAX_FRAME_LEN = 256;

  typedef enum logic [2:0] {
    CLR    = 3'd0,
    RUN    = 3'd1,
    DRAIN1 = 3'd2,
    DRAIN2 = 3'd3,
    OUT    = 3'd4
  } accum_frame_state_e;

endpackage

`default_nettype wire

// File: rtl/accum_frame_ctrl.sv
// accum_frame_ctrl: frames a valid/ready sample stream into the external accum block and
// returns per-frame sum/count. Optional overflow flag under ACCUM_FRAME_OVF_EN. Rev 1.0
`default_nettype none

module accum_frame_ctrl
  import accum_pkg::*;
#(
  parameter int DIN_WIDTH     = ACC_DIN_WIDTH,
  parameter int DOUT_WIDTH    = ACC_DOUT_WIDTH,
  parameter int MAX_FRAME_LEN = ACC_MAX_FRAME_LEN,
  localparam int CNT_W        = $clog2(MAX_FRAME_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DIN_WIDTH-1:0]  s_data_i,
  input  logic                  s_last_i,
  output logic                  acc_clear_o,
  output logic                  acc_en_o,
  output logic [DIN_WIDTH-1:0]  acc_data_o,
  input  logic [DOUT_WIDTH-1:0] acc_result_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DOUT_WIDTH-1:0] m_sum_o,
  output logic [CNT_W-1:0]      m_count_o,
  output logic                  m_trunc_o,
  output logic                  m_ovf_o
);

  accum_frame_state_e r_state;
  accum_frame_state_e w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_trunc;
  logic             w_accept;
  logic             w_at_max;
  logic             w_close;

  assign w_accept  = (r_state == RUN) & s_valid_i;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_at_max  = (w_cnt_inc == CNT_W'(MAX_FRAME_LEN));
  assign w_close   = w_accept & (s_last_i | w_at_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_ready_o   = 1'b0;
    acc_clear_o = 1'b0;
    m_valid_o   = 1'b0;
    case (r_state)
      CLR: begin
        acc_clear_o = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        s_ready_o = 1'b1;
        if (w_close) begin
          w_state_nxt = DRAIN1;
        end
      end
      DRAIN1: w_state_nxt = DRAIN2;
      DRAIN2: w_state_nxt = OUT;
      OUT: begin
        m_valid_o = 1'b1;
        if (m_ready_i) begin
          w_state_nxt = CLR;
        end
      end
      default: begin
        acc_clear_o = 1'b1;
        w_state_nxt = CLR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_en_o   <= 1'b0;
      acc_data_o <= '0;
      r_cnt      <= '0;
      r_trunc    <= 1'b0;
    end else begin
      acc_en_o <= w_accept;
      if (w_accept) begin
        acc_data_o <= s_data_i;
      end
      if (r_state == CLR) begin
        r_cnt   <= '0;
        r_trunc <= 1'b0;
      end else if (w_accept) begin
        r_cnt <= w_cnt_inc;
        // A last marker on the limit beat is an ordinary frame end.
        if (w_at_max && !s_last_i) begin
          r_trunc <= 1'b1;
        end
      end
    end
  end

  // The accumulator has finished the final add by the DRAIN2 exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sum_o   <= '0;
      m_count_o <= '0;
      m_trunc_o <= 1'b0;
    end else if (r_state == DRAIN2) begin
      m_sum_o   <= acc_result_i;
      m_count_o <= r_cnt;
      m_trunc_o <= r_trunc;
    end
  end

`ifdef ACCUM_FRAME_OVF_EN
  localparam int SH_W = DOUT_WIDTH + CNT_W;

  logic signed [SH_W-1:0]   r_shadow;
  logic signed [SH_W-1:0]   w_shadow_nxt;
  logic [SH_W-DOUT_WIDTH:0] w_top;
  logic                     w_fits;
  logic                     r_ovf;

  assign w_shadow_nxt = r_shadow + SH_W'($signed(s_data_i));
  // Representable in signed DOUT_WIDTH iff the bits above the sign bit all match it.
  assign w_top        = w_shadow_nxt[SH_W-1:DOUT_WIDTH-1];
  assign w_fits       = (&w_top) | ~(|w_top);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_ovf    <= 1'b0;
      m_ovf_o  <= 1'b0;
    end else begin
      if (r_state == CLR) begin
        r_shadow <= '0;
        r_ovf    <= 1'b0;
      end else if (w_accept) begin
        r_shadow <= w_shadow_nxt;
        if (!w_fits) begin
          r_ovf <= 1'b1;
        end
      end
      if (r_state == DRAIN2) begin
        m_ovf_o <= r_ovf;
      end
    end
  end
`else
  assign m_ovf_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_accum_frame_ctrl.sv
// tb_accum_frame_ctrl: directed bench for accum_frame_ctrl with a behavioural accum alongside.
// Rev 1.0
`default_nettype none

module tb_accum_frame_ctrl;

  localparam int DW   = 32;
  localparam int OW   = 32;
  localparam int MAXL = 4;
  localparam int CW   = $clog2(MAXL + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i = '0;
  logic          s_last_i = 1'b0;
  logic          acc_clear_o;
  logic          acc_en_o;
  logic [DW-1:0] acc_data_o;
  logic [OW-1:0] acc_result_i;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [OW-1:0] m_sum_o;
  logic [CW-1:0] m_count_o;
  logic          m_trunc_o;
  logic          m_ovf_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_ovf;

  accum_frame_ctrl #(
    .DIN_WIDTH    (DW),
    .DOUT_WIDTH   (OW),
    .MAX_FRAME_LEN(MAXL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .s_last_i    (s_last_i),
    .acc_clear_o (acc_clear_o),
    .acc_en_o    (acc_en_o),
    .acc_data_o  (acc_data_o),
    .acc_result_i(acc_result_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_sum_o     (m_sum_o),
    .m_count_o   (m_count_o),
    .m_trunc_o   (m_trunc_o),
    .m_ovf_o     (m_ovf_o)
  );

  always #5 clk = ~clk;

  // Behavioural accumulator: no reset, clear has priority, wraps modulo 2^OW.
  always @(posedge clk) begin
    if (acc_clear_o) acc_result_i <= '0;
    else if (acc_en_o) acc_result_i <= acc_result_i + OW'($signed(acc_data_o));
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) check_eq("clr_en_exclusive", 64'(acc_clear_o & acc_en_o), 64'd0);
  end

  task automatic send_beat(input logic [DW-1:0] data, input logic last);
    int guard = 0;
    s_valid_i = 1'b1;
    s_data_i  = data;
    s_last_i  = last;
    while (!s_ready_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check_eq("accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  // Called one step after the closing accept edge.
  task automatic expect_frame(input string tag, input logic [OW-1:0] sum, input int cnt,
                              input logic trunc, input logic ovf);
    int lat = 0;
    while (!m_valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'd2);
    check_eq({tag, "_sum"},     64'(m_sum_o), 64'(sum));
    check_eq({tag, "_count"},   64'(m_count_o), 64'(cnt));
    check_eq({tag, "_trunc"},   64'(m_trunc_o), 64'(trunc));
    check_eq({tag, "_ovf"},     64'(m_ovf_o), 64'(ovf));
    check_eq({tag, "_sready"},  64'(s_ready_o), 64'd0);
  endtask

  task automatic finish_frame(input string tag);
    m_ready_i = 1'b1;
    @(posedge clk); #1;
    m_ready_i = 1'b0;
    check_eq({tag, "_clr_valid"}, 64'(m_valid_o), 64'd0);
    check_eq({tag, "_clr_clear"}, 64'(acc_clear_o), 64'd1);
    check_eq({tag, "_clr_sready"}, 64'(s_ready_o), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_run_sready"}, 64'(s_ready_o), 64'd1);
    check_eq({tag, "_run_clear"}, 64'(acc_clear_o), 64'd0);
  endtask

  initial begin
`ifdef ACCUM_FRAME_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_clear",  64'(acc_clear_o), 64'd1);
    check_eq("rst_en",     64'(acc_en_o), 64'd0);
    check_eq("rst_sready", 64'(s_ready_o), 64'd0);
    check_eq("rst_mvalid", 64'(m_valid_o), 64'd0);
    check_eq("rst_trunc",  64'(m_trunc_o), 64'd0);
    check_eq("rst_ovf",    64'(m_ovf_o), 64'd0);
    check_eq("rst_data",   64'(acc_data_o), 64'd0);
    check_eq("rst_sum",    64'(m_sum_o), 64'd0);
    check_eq("rst_count",  64'(m_count_o), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_sready", 64'(s_ready_o), 64'd1);

    // Four beats ending exactly at the limit with last set: normal end.
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b0);
    send_beat(32'd4, 1'b1);
    expect_frame("basic", 32'd10, 4, 1'b0, 1'b0);
    finish_frame("basic");

    send_beat(-32'sd5, 1'b0);
    send_beat(32'd3, 1'b1);
    expect_frame("signed", 32'hFFFF_FFFE, 2, 1'b0, 1'b0);
    finish_frame("signed");

    send_beat(32'd5, 1'b0);
    send_beat(32'd6, 1'b1);
    expect_frame("bp", 32'd11, 2, 1'b0, 1'b0);
    s_valid_i = 1'b1;
    s_data_i  = 32'd99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_valid",  64'(m_valid_o), 64'd1);
      check_eq("bp_hold_sum",    64'(m_sum_o), 64'd11);
      check_eq("bp_hold_count",  64'(m_count_o), 64'd2);
      check_eq("bp_hold_sready", 64'(s_ready_o), 64'd0);
    end
    s_valid_i = 1'b0;
    finish_frame("bp");
    send_beat(32'd9, 1'b1);
    expect_frame("after_bp", 32'd9, 1, 1'b0, 1'b0);
    finish_frame("after_bp");

    for (int i = 0; i < 4; i++) send_beat(32'd1, 1'b0);
    expect_frame("trunc", 32'd4, 4, 1'b1, 1'b0);
    finish_frame("trunc");
    send_beat(32'd1, 1'b0);
    send_beat(32'd1, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("trunc_rest_open", 64'(m_valid_o), 64'd0);
    end

    // Discard the open two-beat frame with a reset.
    rst_n = 1'b0;
    #1;
    check_eq("midrst_clear",  64'(acc_clear_o), 64'd1);
    check_eq("midrst_sready", 64'(s_ready_o), 64'd0);
    check_eq("midrst_en",     64'(acc_en_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(32'd7, 1'b1);
    expect_frame("midrst", 32'd7, 1, 1'b0, 1'b0);
    finish_frame("midrst");

    send_beat(32'h7FFF_FFFF, 1'b0);
    send_beat(32'd1, 1'b1);
    expect_frame("ovf", 32'h8000_0000, 2, 1'b0, exp_ovf);
    finish_frame("ovf");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
